// File: rtl/adc_spi_cfg_sequencer_pkg.sv
// Shared definitions for the ADC SPI configuration sequencer: FSM states,
// init-table entry layout, default ACK timeout and SPI request type codes.
package adc_spi_cfg_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT_FETCH,
        ST_INIT_ISSUE,
        ST_INIT_WAIT,
        ST_HOST_ISSUE,
        ST_HOST_WAIT
    } state_t;

    // Table entry layout: {addr[12:0], data[7:0]}
    localparam int ADDR_MSB = 20;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;

    localparam int DEFAULT_TIMEOUT = 4096;

    typedef enum logic {
        REQ_WRITE = 1'b0,
        REQ_READ  = 1'b1
    } req_type_t;

endpackage

// File: rtl/adc_spi_cfg_sequencer_host_latch.sv
// Host-side request capture: pending flag, latched request, and the
// HOST_ACK / HOST_RD / HOST_TOERR output registers.
module adc_spi_host_latch
    import adc_spi_cfg_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        host_select,
    input  logic [12:0] host_addr,
    input  logic        host_we,
    input  logic [7:0]  host_wd,
    input  logic        host_re,
    input  logic        issue,
    input  logic        done,
    input  logic        timeout,
    input  logic [7:0]  spi_rd,
    output logic        capture,
    output logic        pending,
    output logic [12:0] req_addr,
    output logic [7:0]  req_wd,
    output logic        req_read,
    output logic [7:0]  host_rd,
    output logic        host_ack,
    output logic        host_toerr
);

    logic        pending_reg;
    logic [12:0] addr_reg;
    logic [7:0]  wd_reg;
    req_type_t   type_reg;
    logic [7:0]  rd_reg;
    logic        ack_reg;
    logic        toerr_reg;

    // A new request is only accepted once the previous one has been retired.
    assign capture = host_select & (host_we | host_re) & ~pending_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= 1'b0;
            addr_reg    <= '0;
            wd_reg      <= '0;
            type_reg    <= REQ_WRITE;
            rd_reg      <= '0;
            ack_reg     <= 1'b0;
            toerr_reg   <= 1'b0;
        end else begin
            ack_reg <= done;
            if (capture) begin
                pending_reg <= 1'b1;
                addr_reg    <= host_addr;
                wd_reg      <= host_wd;
                type_reg    <= host_we ? REQ_WRITE : REQ_READ;
            end else if (done || timeout) begin
                pending_reg <= 1'b0;
            end
            if (done && type_reg == REQ_READ) begin
                rd_reg <= spi_rd;
            end
            if (issue) begin
                toerr_reg <= 1'b0;
            end else if (timeout) begin
                toerr_reg <= 1'b1;
            end
        end
    end

    assign pending    = pending_reg;
    assign req_addr   = addr_reg;
    assign req_wd     = wd_reg;
    assign req_read   = (type_reg == REQ_READ);
    assign host_rd    = rd_reg;
    assign host_ack   = ack_reg;
    assign host_toerr = toerr_reg;

endmodule

// File: rtl/adc_spi_cfg_sequencer.sv
// Arbitrates one SPI master between the RBCP host and a power-up init-table
// sequencer, one outstanding transaction at a time with an ACK timeout.
module adc_spi_cfg_sequencer
    import adc_spi_cfg_sequencer_pkg::*;
#(
    parameter int TBL_AW      = 4,
    parameter int NUM_ENTRIES = 16,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              HOST_SELECT,
    input  logic [12:0]       HOST_ADDR,
    input  logic              HOST_WE,
    input  logic [7:0]        HOST_WD,
    input  logic              HOST_RE,
    output logic [7:0]        HOST_RD,
    output logic              HOST_ACK,
    input  logic              INIT_START,
    output logic              INIT_BUSY,
    output logic              INIT_DONE,
    output logic              INIT_ERR,
    output logic              HOST_TOERR,
    output logic [TBL_AW-1:0] TBL_ADDR,
    input  logic [20:0]       TBL_DATA,
    output logic              SPI_SELECT,
    output logic [12:0]       SPI_ADDR,
    output logic              SPI_WE,
    output logic [7:0]        SPI_WD,
    output logic              SPI_RE,
    input  logic [7:0]        SPI_RD,
    input  logic              SPI_ACK
);

    localparam logic [TBL_AW-1:0] LAST_IDX = TBL_AW'(NUM_ENTRIES - 1);
    localparam logic [TBL_AW-1:0] IDX_ONE  = TBL_AW'(1);
    localparam logic [15:0]       TO_LAST  = 16'(TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic [TBL_AW-1:0] index_reg, index_next;
    logic [15:0]       count_reg, count_next, count_inc;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic              start_reg, start_next;
    logic [12:0]       spi_addr_reg, spi_addr_next;
    logic [7:0]        spi_wd_reg, spi_wd_next;

    logic              spi_sel, spi_we, spi_re;
    logic              host_issue, host_done, host_timeout;
    logic              capture, pending, req_read;
    logic [12:0]       req_addr;
    logic [7:0]        req_wd;

    adc_spi_host_latch u_host_latch (
        .clk         (CLK),
        .rst         (RST),
        .host_select (HOST_SELECT),
        .host_addr   (HOST_ADDR),
        .host_we     (HOST_WE),
        .host_wd     (HOST_WD),
        .host_re     (HOST_RE),
        .issue       (host_issue),
        .done        (host_done),
        .timeout     (host_timeout),
        .spi_rd      (SPI_RD),
        .capture     (capture),
        .pending     (pending),
        .req_addr    (req_addr),
        .req_wd      (req_wd),
        .req_read    (req_read),
        .host_rd     (HOST_RD),
        .host_ack    (HOST_ACK),
        .host_toerr  (HOST_TOERR)
    );

    assign count_inc = (count_reg == 16'hFFFF) ? count_reg : count_reg + 16'd1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg    <= ST_IDLE;
            index_reg    <= '0;
            count_reg    <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            start_reg    <= 1'b0;
            spi_addr_reg <= '0;
            spi_wd_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            index_reg    <= index_next;
            count_reg    <= count_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            start_reg    <= start_next;
            spi_addr_reg <= spi_addr_next;
            spi_wd_reg   <= spi_wd_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        index_next    = index_reg;
        count_next    = count_reg;
        busy_next     = busy_reg;
        done_next     = done_reg;
        err_next      = err_reg;
        // A start request seen while idle-but-occupied is remembered until taken.
        start_next    = start_reg | (INIT_START & ~busy_reg);
        spi_addr_next = spi_addr_reg;
        spi_wd_next   = spi_wd_reg;
        spi_sel       = 1'b0;
        spi_we        = 1'b0;
        spi_re        = 1'b0;
        host_issue    = 1'b0;
        host_done     = 1'b0;
        host_timeout  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (pending) begin
                    state_next = ST_HOST_ISSUE;
                end else if (capture) begin
                    state_next = ST_IDLE;
                end else if (INIT_START || start_reg) begin
                    state_next = ST_INIT_FETCH;
                    index_next = '0;
                    busy_next  = 1'b1;
                    done_next  = 1'b0;
                    err_next   = 1'b0;
                    start_next = 1'b0;
                end
            end
            ST_INIT_FETCH: begin
                state_next = ST_INIT_ISSUE;
            end
            ST_INIT_ISSUE: begin
                spi_sel       = 1'b1;
                spi_we        = 1'b1;
                spi_addr_next = TBL_DATA[ADDR_MSB:ADDR_LSB];
                spi_wd_next   = TBL_DATA[DATA_MSB:0];
                count_next    = '0;
                state_next    = ST_INIT_WAIT;
            end
            ST_INIT_WAIT: begin
                count_next = count_inc;
                if (SPI_ACK) begin
                    if (index_reg == LAST_IDX) begin
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        index_next = index_reg + IDX_ONE;
                        state_next = pending ? ST_HOST_ISSUE : ST_INIT_FETCH;
                    end
                end else if (count_reg == TO_LAST) begin
                    busy_next  = 1'b0;
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_HOST_ISSUE: begin
                spi_sel       = 1'b1;
                spi_we        = ~req_read;
                spi_re        = req_read;
                spi_addr_next = req_addr;
                spi_wd_next   = req_wd;
                count_next    = '0;
                host_issue    = 1'b1;
                state_next    = ST_HOST_WAIT;
            end
            ST_HOST_WAIT: begin
                count_next = count_inc;
                if (SPI_ACK) begin
                    host_done  = 1'b1;
                    state_next = busy_reg ? ST_INIT_FETCH : ST_IDLE;
                end else if (count_reg == TO_LAST) begin
                    host_timeout = 1'b1;
                    state_next   = busy_reg ? ST_INIT_FETCH : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign SPI_SELECT = spi_sel;
    assign SPI_WE     = spi_we;
    assign SPI_RE     = spi_re;
    assign SPI_ADDR   = spi_addr_next;
    assign SPI_WD     = spi_wd_next;
    assign TBL_ADDR   = index_reg;
    assign INIT_BUSY  = busy_reg;
    assign INIT_DONE  = done_reg;
    assign INIT_ERR   = err_reg;

endmodule

// File: tb/tb_adc_spi_cfg_sequencer.sv
// Directed bench for adc_spi_cfg_sequencer with an SPI-master model and a
// scoreboard of expected SPI transactions and host acknowledges.
module tb_adc_spi_cfg_sequencer;

    localparam int TBL_AW      = 4;
    localparam int NUM_ENTRIES = 4;
    localparam int TIMEOUT     = 100;
    localparam int ACK_DELAY   = 50;
    localparam int LATE_DELAY  = 150;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              HOST_SELECT;
    logic [12:0]       HOST_ADDR;
    logic              HOST_WE;
    logic [7:0]        HOST_WD;
    logic              HOST_RE;
    logic [7:0]        HOST_RD;
    logic              HOST_ACK;
    logic              INIT_START;
    logic              INIT_BUSY;
    logic              INIT_DONE;
    logic              INIT_ERR;
    logic              HOST_TOERR;
    logic [TBL_AW-1:0] TBL_ADDR;
    logic [20:0]       TBL_DATA = '0;
    logic              SPI_SELECT;
    logic [12:0]       SPI_ADDR;
    logic              SPI_WE;
    logic [7:0]        SPI_WD;
    logic              SPI_RE;
    logic [7:0]        SPI_RD;
    logic              SPI_ACK;

    always #5 CLK = ~CLK;

    adc_spi_cfg_sequencer #(
        .TBL_AW      (TBL_AW),
        .NUM_ENTRIES (NUM_ENTRIES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .HOST_SELECT (HOST_SELECT),
        .HOST_ADDR   (HOST_ADDR),
        .HOST_WE     (HOST_WE),
        .HOST_WD     (HOST_WD),
        .HOST_RE     (HOST_RE),
        .HOST_RD     (HOST_RD),
        .HOST_ACK    (HOST_ACK),
        .INIT_START  (INIT_START),
        .INIT_BUSY   (INIT_BUSY),
        .INIT_DONE   (INIT_DONE),
        .INIT_ERR    (INIT_ERR),
        .HOST_TOERR  (HOST_TOERR),
        .TBL_ADDR    (TBL_ADDR),
        .TBL_DATA    (TBL_DATA),
        .SPI_SELECT  (SPI_SELECT),
        .SPI_ADDR    (SPI_ADDR),
        .SPI_WE      (SPI_WE),
        .SPI_WD      (SPI_WD),
        .SPI_RE      (SPI_RE),
        .SPI_RD      (SPI_RD),
        .SPI_ACK     (SPI_ACK)
    );

    typedef struct packed {
        logic        we;
        logic [12:0] addr;
        logic [7:0]  wd;
    } spi_txn_t;

    spi_txn_t   spi_exp[$];
    logic [8:0] host_exp[$];
    logic [20:0] tbl_mem [16];

    int tests_run      = 0;
    int tests_failed   = 0;
    int cyc            = 0;
    int issue_count    = 0;
    int host_ack_count = 0;
    int ack_cnt        = 0;
    int late_issue     = -1;
    int last_issue_cyc = -100;
    int last_ack_cyc   = -100;
    int req_cyc        = 0;
    int base, base_ack, t0;
    logic [7:0] rd_val = 8'h00;
    spi_txn_t   se;
    logic [8:0] he;

    always @(posedge CLK) cyc <= cyc + 1;
    always @(posedge CLK) TBL_DATA <= tbl_mem[TBL_ADDR];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // SPI master model and output monitor, evaluated away from the active edge.
    initial begin
        SPI_ACK = 1'b0;
        SPI_RD  = 8'h00;
        forever begin
            @(negedge CLK);
            SPI_ACK = 1'b0;
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    SPI_ACK      = 1'b1;
                    SPI_RD       = rd_val;
                    last_ack_cyc = cyc;
                end
            end
            if (HOST_ACK) begin
                host_ack_count++;
                check("host_ack_latency", 64'(cyc - last_ack_cyc), 64'd1);
                if (host_exp.size() == 0) begin
                    check("host_ack_unexpected", 64'(HOST_ACK), 64'd0);
                end else begin
                    he = host_exp.pop_front();
                    if (he[8]) check("host_rd", 64'(HOST_RD), 64'(he[7:0]));
                end
            end
            if (SPI_WE || SPI_RE) begin
                issue_count++;
                last_issue_cyc = cyc;
                $display("[TB] cyc %0d spi %s addr=0x%03h wd=0x%02h", cyc, SPI_WE ? "WR" : "RD", SPI_ADDR, SPI_WD);
                check("spi_issue_shape", 64'({SPI_SELECT, SPI_WE & SPI_RE}), 64'b10);
                check("spi_overlap", 64'(ack_cnt), 64'd0);
                if (spi_exp.size() == 0) begin
                    check("spi_unexpected", 64'({SPI_WE, SPI_RE}), 64'd0);
                end else begin
                    se = spi_exp.pop_front();
                    check("spi_we", 64'(SPI_WE), 64'(se.we));
                    check("spi_addr", 64'(SPI_ADDR), 64'(se.addr));
                    if (se.we) check("spi_wd", 64'(SPI_WD), 64'(se.wd));
                end
                ack_cnt = (issue_count == late_issue) ? LATE_DELAY : ACK_DELAY;
            end
        end
    end

    task automatic host_req(input logic is_write, input logic [12:0] addr, input logic [7:0] wd);
        @(negedge CLK);
        HOST_SELECT = 1'b1;
        HOST_WE     = is_write;
        HOST_RE     = ~is_write;
        HOST_ADDR   = addr;
        HOST_WD     = wd;
        req_cyc     = cyc;
        @(negedge CLK);
        HOST_SELECT = 1'b0;
        HOST_WE     = 1'b0;
        HOST_RE     = 1'b0;
    endtask

    task automatic pulse_init();
        @(negedge CLK);
        INIT_START = 1'b1;
        @(negedge CLK);
        INIT_START = 1'b0;
    endtask

    task automatic wait_to_cyc(input int target);
        while (cyc < target) @(negedge CLK);
    endtask

    task automatic wait_issues(input int target, input string tag);
        for (int i = 0; i < 2000 && issue_count < target; i++) @(negedge CLK);
        check(tag, 64'(issue_count), 64'(target));
    endtask

    task automatic wait_host_acks(input int target, input string tag);
        for (int i = 0; i < 2000 && host_ack_count < target; i++) @(negedge CLK);
        check(tag, 64'(host_ack_count), 64'(target));
    endtask

    task automatic wait_init_idle(input string tag);
        for (int i = 0; i < 2000 && INIT_BUSY; i++) @(negedge CLK);
        check(tag, 64'(INIT_BUSY), 64'd0);
    endtask

    task automatic push_entries(input int first, input int last);
        for (int i = first; i <= last; i++) spi_exp.push_back(spi_txn_t'({1'b1, tbl_mem[i]}));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        HOST_SELECT = 1'b0;
        HOST_ADDR   = '0;
        HOST_WE     = 1'b0;
        HOST_WD     = '0;
        HOST_RE     = 1'b0;
        INIT_START  = 1'b0;
        for (int i = 0; i < 16; i++) tbl_mem[i] = '0;
        tbl_mem[0] = {13'h008, 8'h03};
        tbl_mem[1] = {13'h014, 8'h41};
        tbl_mem[2] = {13'h0FF, 8'h01};
        tbl_mem[3] = {13'h016, 8'h80};

        repeat (3) @(negedge CLK);
        check("reset_out_a", 64'({HOST_RD, HOST_ACK, INIT_BUSY, INIT_DONE, INIT_ERR, HOST_TOERR, TBL_ADDR}), 64'd0);
        check("reset_out_b", 64'({SPI_SELECT, SPI_ADDR, SPI_WE, SPI_WD, SPI_RE}), 64'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Full init run
        base = issue_count;
        push_entries(0, 3);
        pulse_init();
        wait_init_idle("init1_idle");
        check("init1_busy_fall", 64'(cyc - last_ack_cyc), 64'd1);
        check("init1_count", 64'(issue_count - base), 64'd4);
        check("init1_done", 64'(INIT_DONE), 64'd1);
        check("init1_err", 64'(INIT_ERR), 64'd0);
        check("init1_queue", 64'(spi_exp.size()), 64'd0);

        // Host read from idle
        rd_val   = 8'hA5;
        base_ack = host_ack_count;
        spi_exp.push_back(spi_txn_t'({1'b0, 13'h001, 8'h00}));
        host_exp.push_back({1'b1, 8'hA5});
        host_req(1'b0, 13'h001, 8'h00);
        wait_host_acks(base_ack + 1, "host_rd_ack");
        check("host_rd_issue_latency", 64'(last_issue_cyc - req_cyc), 64'd2);
        check("host_rd_value", 64'(HOST_RD), 64'hA5);

        // Host write preempting init between entries 2 and 3
        rd_val   = 8'h00;
        base     = issue_count;
        base_ack = host_ack_count;
        push_entries(0, 2);
        spi_exp.push_back(spi_txn_t'({1'b1, 13'h0FF, 8'h01}));
        push_entries(3, 3);
        host_exp.push_back({1'b0, 8'h00});
        pulse_init();
        wait_issues(base + 3, "mix_entry2_issue");
        repeat (10) @(negedge CLK);
        host_req(1'b1, 13'h0FF, 8'h01);
        wait_init_idle("mix_idle");
        check("mix_count", 64'(issue_count - base), 64'd5);
        check("mix_host_ack", 64'(host_ack_count - base_ack), 64'd1);
        check("mix_done", 64'(INIT_DONE), 64'd1);
        check("mix_queue", 64'(spi_exp.size()), 64'd0);

        // Init entry 1 never acknowledged in time
        base       = issue_count;
        late_issue = base + 2;
        push_entries(0, 1);
        pulse_init();
        wait_issues(base + 2, "to_entry1_issue");
        t0 = last_issue_cyc;
        wait_to_cyc(t0 + TIMEOUT - 1);
        check("to_err_early", 64'(INIT_ERR), 64'd0);
        wait_to_cyc(t0 + TIMEOUT + 1);
        check("to_err_set", 64'(INIT_ERR), 64'd1);
        check("to_busy_clear", 64'(INIT_BUSY), 64'd0);
        wait_to_cyc(t0 + 2 * TIMEOUT);
        check("to_no_more_writes", 64'(issue_count - base), 64'd2);
        check("to_done_clear", 64'(INIT_DONE), 64'd0);
        late_issue = -1;

        // Host read timeout, late ACK discarded, next request clears HOST_TOERR
        base       = issue_count;
        base_ack   = host_ack_count;
        late_issue = base + 1;
        rd_val     = 8'h3C;
        spi_exp.push_back(spi_txn_t'({1'b0, 13'h033, 8'h00}));
        host_req(1'b0, 13'h033, 8'h00);
        wait_issues(base + 1, "hto_issue");
        t0 = last_issue_cyc;
        wait_to_cyc(t0 + TIMEOUT + 5);
        check("hto_toerr_set", 64'(HOST_TOERR), 64'd1);
        wait_to_cyc(t0 + LATE_DELAY + 10);
        check("hto_no_ack", 64'(host_ack_count - base_ack), 64'd0);
        check("hto_toerr_hold", 64'(HOST_TOERR), 64'd1);
        late_issue = -1;
        rd_val     = 8'h00;
        spi_exp.push_back(spi_txn_t'({1'b1, 13'h044, 8'h5A}));
        host_exp.push_back({1'b0, 8'h00});
        host_req(1'b1, 13'h044, 8'h5A);
        wait_host_acks(base_ack + 1, "hto_next_ack");
        check("hto_toerr_clear", 64'(HOST_TOERR), 64'd0);

        // Asynchronous reset during INIT_WAIT
        base     = issue_count;
        base_ack = host_ack_count;
        push_entries(0, 0);
        pulse_init();
        wait_issues(base + 1, "rst_entry0_issue");
        repeat (10) @(negedge CLK);
        RST = 1'b1;
        #1;
        check("rst_async_a", 64'({HOST_RD, HOST_ACK, INIT_BUSY, INIT_DONE, INIT_ERR, HOST_TOERR, TBL_ADDR}), 64'd0);
        check("rst_async_b", 64'({SPI_SELECT, SPI_ADDR, SPI_WE, SPI_WD, SPI_RE}), 64'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 200 && ack_cnt != 0; i++) @(negedge CLK);
        repeat (5) @(negedge CLK);
        check("rst_late_ack_state", 64'({INIT_BUSY, INIT_DONE, INIT_ERR, HOST_ACK}), 64'd0);
        check("rst_late_ack_no_host", 64'(host_ack_count - base_ack), 64'd0);
        check("rst_late_ack_no_issue", 64'(issue_count - base), 64'd1);
        push_entries(0, 3);
        pulse_init();
        wait_init_idle("rst_rerun_idle");
        check("rst_rerun_count", 64'(issue_count - base), 64'd5);
        check("rst_rerun_done", 64'(INIT_DONE), 64'd1);
        check("rst_rerun_queue", 64'(spi_exp.size()), 64'd0);

        repeat (5) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
